// File: rtl/pwd_checker.sv
// Password checker: scans a 4-slot password memory for the latched code.
// Define PWD_CHECKER_LOCKOUT_EN to build the consecutive-failure lockout.
module pwd_checker #(
    parameter int MAX_FAIL = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] code,
    input  logic        clear_lock,
    output logic [1:0]  mem_idx,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic [1:0]  match_idx,
    output logic [1:0]  fail_cnt,
    output logic        lockout
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  scan_idx;
    logic [15:0] code_q;
    logic        accept, finish, hit;
    logic        lock_int;

    // An all-zero slot is empty and can never match.
    assign hit = (mem_rdata == code_q) && (mem_rdata != 16'h0000);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !lock_int) begin
                    state_nxt = SCAN;
                    accept    = 1'b1;
                end
            end
            SCAN: begin
                if (hit || scan_idx == 2'd3) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            scan_idx  <= 2'd0;
            code_q    <= 16'h0000;
            match     <= 1'b0;
            match_idx <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                code_q    <= code;
                scan_idx  <= 2'd0;
                match     <= 1'b0;
                match_idx <= 2'd0;
            end else if (state == SCAN && !finish) begin
                scan_idx <= scan_idx + 2'd1;
            end
            if (finish && hit) begin
                match     <= 1'b1;
                match_idx <= scan_idx;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign mem_enable = (state == SCAN);
    assign mem_idx    = (state == SCAN) ? scan_idx : 2'd0;
    assign mem_wr     = 1'b0;

`ifdef PWD_CHECKER_LOCKOUT_EN
    localparam logic [1:0] FAIL_MAX = 2'(MAX_FAIL);

    logic [1:0] fail_q;
    logic [1:0] fail_inc;
    logic       lock_q;

    assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + 2'd1;

    // Counter updates on the edge entering DONE; clear_lock overrides a failing result.
    always_ff @(posedge clk) begin
        if (reset || clear_lock) begin
            fail_q <= 2'd0;
            lock_q <= 1'b0;
        end else if (finish) begin
            if (hit) begin
                fail_q <= 2'd0;
            end else begin
                fail_q <= fail_inc;
                lock_q <= lock_q | (fail_inc == FAIL_MAX);
            end
        end
    end

    assign lock_int = lock_q;
    assign fail_cnt = fail_q;
    assign lockout  = lock_q;
`else
    logic unused_clear_lock;

    assign unused_clear_lock = clear_lock;
    assign lock_int          = 1'b0;
    assign fail_cnt          = 2'd0;
    assign lockout           = 1'b0;
`endif

endmodule

// File: tb/tb_pwd_checker.sv
// Scoreboard bench for pwd_checker; expectations adapt to PWD_CHECKER_LOCKOUT_EN.
module tb_pwd_checker;

    localparam int MAX_FAIL = 3;

    logic        clk = 1'b0;
    logic        reset, start, clear_lock;
    logic [15:0] code;
    logic [1:0]  mem_idx;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_rdata;
    logic        busy, done, match;
    logic [1:0]  match_idx, fail_cnt;
    logic        lockout;

    logic [15:0] mem [4];

    pwd_checker #(.MAX_FAIL(MAX_FAIL)) dut (
        .clk(clk), .reset(reset), .start(start), .code(code), .clear_lock(clear_lock),
        .mem_idx(mem_idx), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .match(match), .match_idx(match_idx),
        .fail_cnt(fail_cnt), .lockout(lockout)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_enable ? mem[mem_idx] : 16'h0000;

    typedef struct {
        logic       m;
        logic [1:0] k;
        logic [1:0] fc;
        logic       lk;
        int         lat;
        int         t0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   m_fc = 0;
    int   m_lk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("match", int'(match), int'(e.m));
                chk("match_idx", int'(match_idx), int'(e.k));
                chk("fail_cnt", int'(fail_cnt), int'(e.fc));
                chk("lockout", int'(lockout), int'(e.lk));
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic update_model(input logic m, input logic clr);
`ifdef PWD_CHECKER_LOCKOUT_EN
        if (clr) begin
            m_fc = 0;
            m_lk = 0;
        end else if (m) begin
            m_fc = 0;
        end else begin
            if (m_fc != MAX_FAIL) m_fc = m_fc + 1;
            if (m_fc == MAX_FAIL) m_lk = 1;
        end
`else
        m_fc = 0;
        m_lk = 0;
`endif
    endtask

    // tamper: keep start high and change code during the scan; neither may matter.
    task automatic run_check(input logic [15:0] c, input logic clr, input logic m,
                             input logic [1:0] k, input logic tamper);
        exp_t e;
        @(posedge clk);
        #1;
        code       = c;
        start      = 1'b1;
        clear_lock = clr;
        update_model(m, clr);
        e.m   = m;
        e.k   = m ? k : 2'd0;
        e.fc  = 2'(m_fc);
        e.lk  = 1'(m_lk);
        e.lat = m ? int'(k) + 2 : 5;
        e.t0  = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (tamper) begin
            code = 16'h5678;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int i = 0; i < 12 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
        #1;
        clear_lock = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({busy, done, match, match_idx, fail_cnt, lockout,
                        mem_enable, mem_idx, mem_wr}), 0);
    endtask

    initial begin
        mem[0] = 16'h1234;
        mem[1] = 16'h0000;
        mem[2] = 16'h5678;
        mem[3] = 16'h9999;
        reset      = 1'b1;
        start      = 1'b1;
        clear_lock = 1'b1;
        code       = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        @(posedge clk);
        #1;
        reset      = 1'b0;
        start      = 1'b0;
        clear_lock = 1'b0;

        run_check(16'h5678, 1'b0, 1'b1, 2'd2, 1'b0);
        run_check(16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);
        run_check(16'h1111, 1'b0, 1'b0, 2'd0, 1'b0);
        run_check(16'h1234, 1'b0, 1'b1, 2'd0, 1'b0);
        run_check(16'h9999, 1'b0, 1'b1, 2'd3, 1'b1);

        run_check(16'h4321, 1'b0, 1'b0, 2'd0, 1'b0);
        run_check(16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);
        run_check(16'h1111, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        chk("lockout_after_3", int'(lockout), m_lk);

`ifdef PWD_CHECKER_LOCKOUT_EN
        begin
            int seen_busy;
            seen_busy = 0;
            @(posedge clk);
            #1;
            code  = 16'h1234;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (busy || done) seen_busy = 1;
            end
            chk("locked_start_ignored", seen_busy, 0);
            @(posedge clk);
            #1;
            clear_lock = 1'b1;
            @(posedge clk);
            #1;
            clear_lock = 1'b0;
            update_model(1'b0, 1'b1);
            @(negedge clk);
            chk("clear_lock_lockout", int'(lockout), 0);
            chk("clear_lock_fail_cnt", int'(fail_cnt), 0);
        end
`else
        run_check(16'h2222, 1'b0, 1'b0, 2'd0, 1'b0);
`endif
        run_check(16'h3333, 1'b0, 1'b0, 2'd0, 1'b0);
        run_check(16'h7777, 1'b1, 1'b0, 2'd0, 1'b0);

        // Reset lands on the second SCAN cycle.
        @(posedge clk);
        #1;
        code  = 16'h9999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_scan_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_abort");
        reset = 1'b0;
        m_fc  = 0;
        m_lk  = 0;
        run_check(16'h1234, 1'b0, 1'b1, 2'd0, 1'b0);
        chk("mem_wr_low", int'(mem_wr), 0);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwd_checker.md
PWD_CHECKER -- requirements
Module: pwd_checker

Interface
REQ-001 Parameter MAX_FAIL, default 3, consecutive failed checks that trigger lockout; legal range 1..3.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a check of code; sampled only in IDLE.
REQ-005 code  input  16  entered code, 4 BCD digits; latched on the accepted start.
REQ-006 clear_lock  input  1  supervisor release of lockout.
REQ-007 mem_idx  output  2  slot index driven to the 4x16-bit password memory.
REQ-008 mem_enable  output  1  memory access enable.
REQ-009 mem_wr  output  1  memory write strobe; constant 0.
REQ-010 mem_rdata  input  16  memory read data; combinational in mem_idx, 0 when not enabled.
REQ-011 busy  output  1  high in SCAN and DONE.
REQ-012 done  output  1  one-cycle pulse ending a check.
REQ-013 match  output  1  result of the last check; held until the next accepted start.
REQ-014 match_idx  output  2  slot that matched; valid while match=1, else 0.
REQ-015 fail_cnt  output  2  consecutive failed checks.
REQ-016 lockout  output  1  checks blocked.

Function
REQ-017 States: IDLE, SCAN, DONE.
REQ-018 IDLE->SCAN on start=1 and lockout=0; latch code, set scan index to 0, clear match and match_idx.
REQ-019 start=1 while lockout=1 is ignored: no state change and no done pulse.
REQ-020 In SCAN: mem_enable=1, mem_wr=0, mem_idx=scan index; mem_rdata is compared in the same cycle.
REQ-021 A slot matches when mem_rdata equals the latched code and mem_rdata is not 16'h0000; an all-zero slot is empty and never matches, so code 16'h0000 always fails.
REQ-022 On the first match at index k: go to DONE, set match=1 and match_idx=k; higher slots are not read.
REQ-023 No match at index 3: go to DONE with match=0; otherwise increment the scan index.
REQ-024 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-025 Latency: start accepted at edge E0 gives done in the cycle after edge E(k+1) for a match at slot k (2..5 cycles), and 5 cycles for no match.
REQ-026 Outside SCAN: mem_enable=0 and mem_idx=0.
REQ-027 start asserted while busy=1 is ignored; code changes during a check have no effect.
REQ-028 On a DONE with match=1, fail_cnt is cleared to 0.
REQ-029 On a DONE with match=0, fail_cnt increments and saturates at MAX_FAIL.
REQ-030 lockout goes to 1 on the edge where fail_cnt reaches MAX_FAIL.
REQ-031 clear_lock=1 in any state clears lockout and fail_cnt on the next edge without aborting a scan in progress.
REQ-032 If clear_lock=1 coincides with a failing DONE, clear_lock wins.

Reset
REQ-033 While reset=1 at an edge: state=IDLE, scan index=0, latched code=0, busy=0, done=0, match=0, match_idx=0, fail_cnt=0, lockout=0, mem_enable=0, mem_idx=0.
REQ-034 Reset during SCAN or DONE aborts the check; no done pulse follows.
REQ-035 Reset takes priority over start and clear_lock.

Configuration
REQ-036 With macro PWD_CHECKER_LOCKOUT_EN defined, REQ-015, REQ-016 and REQ-028..REQ-032 apply as written.
REQ-037 Without PWD_CHECKER_LOCKOUT_EN: no fail counter or lockout logic is built; fail_cnt and lockout are tied to 0; clear_lock is ignored; start is never blocked.

Verification
REQ-038 Memory {1234, 0000, 5678, 9999}, code=16'h5678 -> done 4 cycles after start, match=1, match_idx=2, fail_cnt=0.
REQ-039 Same memory, code=16'h0000 -> slot 1 skipped, done after 5 cycles, match=0, fail_cnt=1.
REQ-040 Three consecutive wrong codes with MAX_FAIL=3 -> lockout=1 after the third done; a fourth start gives no busy and no done; clear_lock pulse -> lockout=0, fail_cnt=0.
REQ-041 Two failed checks, then a correct code 16'h1234 -> match=1, match_idx=0, done 2 cycles after start, fail_cnt returns to 0.
REQ-042 Reset asserted on the 2nd SCAN cycle -> next cycle all outputs 0, no done pulse; start is re-accepted right after reset is released.
REQ-043 Build without PWD_CHECKER_LOCKOUT_EN, five wrong codes -> every start is accepted, lockout=0 and fail_cnt=0 throughout.
